sub_word_store: RTL and testbench

Read-modify-write unit implementing the store-halfword (`sh`) and store-byte (`sb`) instructions against a word-only data memory. It is the store-side counterpart of the halfword extender: it narrows a 32-bit register value to 16 or 8 bits and merges that value into the addressed word lane. It sits between the execute stage and the data-memory port, and stalls the CPU through `busy` until the merged word is written back.

---
 rtl/sub_word_store.sv | 187 ++++++++++++++++++
 tb/tb_sub_word_store.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_word_store.sv
// sub_word_store: read-modify-write engine for sh/sb against a word-only
// data memory. It latches the request, reads the containing word, merges
// the narrowed store value into the addressed lane (little-endian) and
// writes the word back, holding busy for the whole sequence.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, op_half           request pulse (IDLE only); 1 = sh, 0 = sb
//   addr, wdata              byte address and register value, latched on start
//   busy, done, err          stall, one-cycle completion, misalignment (with done)
//   mem_addr, mem_rd         word-aligned address, one-cycle read request
//   mem_rdata, mem_rvalid    read return
//   mem_wr, mem_wdata        one-cycle write strobe and merged word
//
// Build option: define SUB_WORD_STORE_ALIGN_CHECK_EN to reject sh with
// addr[0]=1 (done+err two cycles after start, no memory traffic). Without
// it addr[0] is ignored for sh and err is always 0.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | mem_rd asserted for one cycle
// WAIT   | waiting for mem_rvalid, merged word captured on it
// WR     | mem_wr asserted with merged word
// DONE   | done pulse (misaligned path spends one extra cycle here first)

module sub_word_store #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_half,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

`ifdef SUB_WORD_STORE_ALIGN_CHECK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic              half_q, half_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              misalign;
  logic [31:0]       merged;

  // Bits above the stored width are discarded by definition.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^wdata[31:16];

  assign misalign = ALIGN_CHK & op_half & addr[0];

  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    lane_d      = lane_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          half_d     = op_half;
          lane_d     = addr[1:0];
          data_d     = wdata[15:0];
          mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
          busy_d     = 1'b1;
          if (misalign) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            rd_d    = 1'b1;
          end
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          mem_wdata_d = merged;
          wr_d        = 1'b1;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Entered with done_q low only from the misaligned shortcut: emit
        // the done/err pulse one cycle later so it lands two cycles after start.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
          err_d  = ALIGN_CHK;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      half_q      <= 1'b0;
      lane_q      <= 2'd0;
      data_q      <= 16'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      lane_q      <= lane_d;
      data_q      <= data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sub_word_store.sv
// Bench for sub_word_store: directed cases from the store scenarios plus
// randomized requests compared against an arithmetic lane-merge model.
module tb_sub_word_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_half;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sub_word_store #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_half(op_half), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: clear the stored-width field at its byte offset, OR in the
  // truncated register value shifted to that offset.
  function automatic logic [31:0] ref_merge(input bit half, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [31:0] old);
    int sh;
    logic [31:0] mask;
    logic [31:0] val;
    if (half) begin
      sh   = a[1] ? 16 : 0;
      mask = 32'h0000FFFF << sh;
      val  = (wd & 32'h0000FFFF) << sh;
    end else begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'h000000FF << sh;
      val  = (wd & 32'h000000FF) << sh;
    end
    return (old & ~mask) | val;
  endfunction

  // Issue one request and follow it cycle by cycle (k = cycles after the
  // accepting edge, sampled at the falling edge).
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] old, input int waits, input bit stray,
                        output logic [31:0] seen_wdata, output bit seen_err);
    bit misal;
    int rd_k;
    int wr_k;
    int done_k;
    int n_rd;
    int n_wr;
    int late_rd;
    logic [31:0] exp_w;
    logic [31:0] exp_addr;
    misal  = 1'b0;
`ifdef SUB_WORD_STORE_ALIGN_CHECK_EN
    misal  = half && a[0];
`endif
    rd_k   = -1;
    wr_k   = -1;
    done_k = -1;
    n_rd   = 0;
    n_wr   = 0;
    exp_w  = ref_merge(half, a, wd, old);
    exp_addr = {a[31:2], 2'b00};
    seen_wdata = 32'hx;
    seen_err   = 1'b0;
    @(negedge clk);
    start = 1'b1; op_half = half; addr = a; wdata = wd;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      start = 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      if (mem_rd) begin
        n_rd++;
        if (rd_k < 0) rd_k = k;
        check_val("rd_addr", mem_addr, exp_addr);
      end
      if (mem_wr) begin
        n_wr++;
        wr_k = k;
        seen_wdata = mem_wdata;
        check_val("wr_addr", mem_addr, exp_addr);
      end
      if (done) begin
        done_k = k;
        seen_err = err;
      end
      if (done_k > 0 && k == done_k + 1) begin
        check_val("busy_after_done", busy, 1'b0);
        break;
      end
      check_val("busy_during", busy, 1'b1);
      mem_rvalid = (rd_k > 0) && (k == rd_k + 1 + waits);
      mem_rdata  = mem_rvalid ? old : $urandom;
      if (stray && k == 2) begin
        start = 1'b1; op_half = ~half; addr = $urandom; wdata = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mem_rvalid = 1'b0;
    check_val("done_seen", done_k > 0, 1'b1);
    if (misal) begin
      check_val("mis_done_cycle", done_k, 2);
      check_val("mis_rd_count", n_rd, 0);
      check_val("mis_wr_count", n_wr, 0);
      check_val("mis_err", seen_err, 1'b1);
    end else begin
      check_val("rd_cycle", rd_k, 1);
      check_val("rd_count", n_rd, 1);
      check_val("wr_count", n_wr, 1);
      check_val("wr_cycle", wr_k, 3 + waits);
      check_val("done_cycle", done_k, 4 + waits);
      check_val("merged_word", seen_wdata, exp_w);
      check_val("err_zero", seen_err, 1'b0);
    end
    if (stray) begin
      late_rd = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (mem_rd || mem_wr || busy) late_rd++;
      end
      check_val("stray_start_ignored", late_rd, 0);
    end
  endtask

  logic [31:0] got_w;
  bit          got_e;
  logic [31:0] lane_exp [4] = '{32'hFFFFFFAB, 32'hFFFFABFF, 32'hFFABFFFF, 32'hABFFFFFF};
  int          activity;

  initial begin
    rst = 1'b1; start = 1'b0; op_half = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_rd_wr", {mem_rd, mem_wr}, 2'b00);
    check_val("rst_addr", mem_addr, 32'h0);
    check_val("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 32'h1000, 32'hDEADBEEF, 32'h11223344, 0, 1'b0, got_w, got_e);
    check_val("sh_low", got_w, 32'h1122BEEF);
    run_op(1'b1, 32'h1002, 32'h0000CAFE, 32'h11223344, 3, 1'b0, got_w, got_e);
    check_val("sh_high_wait", got_w, 32'hCAFE3344);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 32'h2000 + i, 32'h000000AB, 32'hFFFFFFFF, i % 2, 1'b0, got_w, got_e);
      check_val("sb_lane", got_w, lane_exp[i]);
    end

    run_op(1'b1, 32'h1001, 32'hDEADBEEF, 32'h11223344, 0, 1'b0, got_w, got_e);
`ifdef SUB_WORD_STORE_ALIGN_CHECK_EN
    check_val("mis_sh_err", got_e, 1'b1);
`else
    check_val("mis_sh_as_aligned", got_w, 32'h1122BEEF);
    check_val("mis_sh_no_err", got_e, 1'b0);
`endif

    run_op(1'b0, 32'h3001, 32'h12345678, 32'hA5A5A5A5, 1, 1'b1, got_w, got_e);
    check_val("stray_start_word", got_w, 32'hA5A578A5);

    // Stray read return while idle must not wake the unit.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    activity = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || mem_rd || mem_wr || done) activity++;
      @(negedge clk);
    end
    check_val("stray_rvalid_idle", activity, 0);

    // Reset while waiting for the read return.
    start = 1'b1; op_half = 1'b1; addr = 32'h4000; wdata = 32'h0000BEEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_outputs", {busy, done, err, mem_rd, mem_wr}, 5'b0);
    check_val("rst_mid_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    activity = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy || mem_wr || mem_rd || done) activity++;
      @(negedge clk);
    end
    check_val("rst_no_write", activity, 0);
    run_op(1'b1, 32'h4002, 32'h0000BEEF, 32'h55555555, 0, 1'b0, got_w, got_e);
    check_val("post_rst_op", got_w, 32'hBEEF5555);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), 1'b0, got_w, got_e);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
